// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: IF state encoding, reset/NOP defaults, opcodes, IF/ID payload.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  // Major opcodes shared with the decoder
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-state / next-address priority mux for the fetch stage.
module pc_next_sel
  import pipeline_pkg::*;
(
  input  logic [XLEN-1:0] reset_pc,
  input  if_state_e       state_q,
  input  logic [XLEN-1:0] pc_q,
  input  logic            vld_q,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output if_state_e       state_d,
  output logic [XLEN-1:0] pc_d,
  output logic            vld_d,
  output logic            misalign_set_c,
  output logic [XLEN-1:0] imem_addr_c
);

  // Priority: misaligned redirect > redirect > stall > sequential
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    vld_d          = vld_q;
    misalign_set_c = 1'b0;
    imem_addr_c    = pc_q;

    unique case (state_q)
      BOOT: begin
        imem_addr_c = reset_pc;
        state_d     = RUN;
        pc_d        = reset_pc;
        vld_d       = 1'b1;
      end
      RUN: begin
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
          state_d        = HALT;
          misalign_set_c = 1'b1;
          vld_d          = 1'b0;
        end else if (redirect) begin
          imem_addr_c = redirect_pc;
          pc_d        = redirect_pc;
          vld_d       = 1'b1;
        end else if (!stall) begin
          imem_addr_c = pc_q + XLEN'(4);
          pc_d        = pc_q + XLEN'(4);
          vld_d       = 1'b1;
        end
      end
      HALT: begin
        vld_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the sync ROM, presents {instr,pc,valid} to ID.
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid,
  output logic        fetch_misalign
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            vld_q, vld_d;
  logic            misalign_q, misalign_d;
  logic            misalign_set_c;
  logic [XLEN-1:0] sel_addr_c;
  logic            valid_c;
  if_id_t          if_id_c;

  pc_next_sel u_pc_next_sel (
    .reset_pc       (RESET_PC),
    .state_q        (state_q),
    .pc_q           (pc_q),
    .vld_q          (vld_q),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .state_d        (state_d),
    .pc_d           (pc_d),
    .vld_d          (vld_d),
    .misalign_set_c (misalign_set_c),
    .imem_addr_c    (sel_addr_c)
  );

  always_comb begin
    misalign_d = misalign_q | misalign_set_c;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      vld_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      vld_q      <= vld_d;
      misalign_q <= misalign_d;
    end
  end

  // Outputs are forced to their reset view while reset_n is low, ahead of the first edge
  always_comb begin
    valid_c       = reset_n & vld_q & (state_q == RUN) & ~redirect;
    if_id_c.valid = valid_c;
    if_id_c.pc    = reset_n ? pc_q : RESET_PC;
    if_id_c.instr = valid_c ? imem_rdata : NOP_INSTR;
  end

  assign imem_addr      = reset_n ? sel_addr_c : RESET_PC;
  assign instr          = if_id_c.instr;
  assign pc             = if_id_c.pc;
  assign valid          = if_id_c.valid;
  assign fetch_misalign = reset_n & misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: sync ROM model (word = addr ^ A5A5_0000) plus rule-level fetch model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] SALT   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        fetch_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the stage should be presenting, by the fetch rules
  bit          m_booted = 1'b0;
  bit          m_halted = 1'b0;
  bit          m_live   = 1'b0;
  bit          m_mis    = 1'b0;
  logic [31:0] m_pc     = RST_PC;

  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_addr;
  logic [31:0] exp_instr;
  logic        exp_mis;

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .pc             (pc),
    .valid          (valid),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle latency
  always @(posedge clk) imem_rdata <= imem_addr ^ SALT;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_outputs();
    if (!reset_n) begin
      exp_valid = 1'b0; exp_pc = RST_PC; exp_addr = RST_PC; exp_mis = 1'b0;
    end else if (!m_booted) begin
      exp_valid = 1'b0; exp_pc = m_pc; exp_addr = RST_PC; exp_mis = m_mis;
    end else if (m_halted) begin
      exp_valid = 1'b0; exp_pc = m_pc; exp_addr = m_pc; exp_mis = 1'b1;
    end else begin
      exp_mis   = m_mis;
      exp_pc    = m_pc;
      exp_valid = m_live && !redirect;
      if (redirect && redirect_pc[1:0] != 2'b00) exp_addr = m_pc;
      else if (redirect)                          exp_addr = redirect_pc;
      else if (stall)                             exp_addr = m_pc;
      else                                        exp_addr = m_pc + 32'd4;
    end
    exp_instr = exp_valid ? (exp_pc ^ SALT) : NOP;
  endtask

  // Drive inputs just after a rising edge, then move to the falling edge for sampling
  task automatic apply(input logic st, input logic rd, input logic [31:0] rpc, input logic rn);
    stall = st; redirect = rd; redirect_pc = rpc; reset_n = rn;
    @(negedge clk);
    model_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      m_booted = 1'b0; m_halted = 1'b0; m_live = 1'b0; m_mis = 1'b0; m_pc = RST_PC;
    end else if (!m_booted) begin
      m_booted = 1'b1; m_live = 1'b1; m_pc = RST_PC;
    end else if (!m_halted) begin
      if (redirect && redirect_pc[1:0] != 2'b00) begin
        m_halted = 1'b1; m_mis = 1'b1; m_live = 1'b0;
      end else if (redirect) begin
        m_pc = redirect_pc; m_live = 1'b1;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4; m_live = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 32'h0000_0040, 1'b0);
      n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_tests++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
      n_tests++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RST_PC); end
      n_tests++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
      n_tests++; if (fetch_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", fetch_misalign); end
      tick();
    end
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b expected 0", valid); end
    n_tests++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL boot_addr: got %h expected %h", imem_addr, RST_PC); end
    tick();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b1);
      n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, valid); end
      n_tests++; if (pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, 32'(4 * i)); end
      n_tests++; if (instr !== (32'(4 * i) ^ SALT)) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, instr, 32'(4 * i) ^ SALT); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) apply(1'b1, 1'b0, 32'h0, 1'b1);
      else begin stall = 1'b1; #1; model_outputs(); end
      n_tests++; if (pc !== 32'h8 || valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got pc=%h v=%b expected pc=8 v=1", i, pc, valid); end
      n_tests++; if (instr !== 32'hA5A5_0008) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h expected a5a50008", i, instr); end
      n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 8", i, imem_addr); end
      tick();
    end
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL unstall_addr: got %h expected c", imem_addr); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (pc !== 32'hC || valid !== 1'b1) begin n_fail++; $display("FAIL unstall_pc: got pc=%h v=%b expected pc=c v=1", pc, valid); end
    tick();
  endtask

  task automatic test_redirect();
    apply(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    n_tests++; if (pc !== 32'h10) begin n_fail++; $display("FAIL redir_src_pc: got %h expected 10", pc); end
    n_tests++; if (valid !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL redir_squash: got v=%b instr=%h expected v=0 instr=%h", valid, instr, NOP); end
    n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %h expected 100", imem_addr); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (pc !== 32'h100 || valid !== 1'b1) begin n_fail++; $display("FAIL redir_target: got pc=%h v=%b expected pc=100 v=1", pc, valid); end
    n_tests++; if (instr !== 32'hA5A5_0100) begin n_fail++; $display("FAIL redir_instr: got %h expected a5a50100", instr); end
    tick();
  endtask

  task automatic test_redirect_stall();
    apply(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    n_tests++; if (valid !== 1'b0 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rs_cycle: got v=%b addr=%h expected v=0 addr=200", valid, imem_addr); end
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b1);
    n_tests++; if (pc !== 32'h200 || valid !== 1'b1) begin n_fail++; $display("FAIL rs_target: got pc=%h v=%b expected pc=200 v=1", pc, valid); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (pc !== 32'h200 || instr !== 32'hA5A5_0200) begin n_fail++; $display("FAIL rs_hold: got pc=%h instr=%h expected pc=200 instr=a5a50200", pc, instr); end
    tick();
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got v=%b expected 0", valid); end
    tick();
    apply(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    n_tests++; if (pc !== 32'h300 || valid !== 1'b0 || imem_addr !== 32'h400) begin n_fail++; $display("FAIL b2b_second: got pc=%h v=%b addr=%h expected pc=300 v=0 addr=400", pc, valid, imem_addr); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (pc !== 32'h400 || valid !== 1'b1 || instr !== 32'hA5A5_0400) begin n_fail++; $display("FAIL b2b_target: got pc=%h v=%b instr=%h expected pc=400 v=1 instr=a5a50400", pc, valid, instr); end
    tick();
  endtask

  task automatic test_wrap();
    apply(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got pc=%h addr=%h expected pc=fffffffc addr=0", pc, imem_addr); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (pc !== 32'h0 || valid !== 1'b1 || instr !== SALT) begin n_fail++; $display("FAIL wrap_pc: got pc=%h v=%b instr=%h expected pc=0 v=1 instr=%h", pc, valid, instr, SALT); end
    tick();
  endtask

  task automatic test_misalign();
    logic [31:0] frozen;
    apply(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    frozen = m_pc;
    n_tests++; if (valid !== 1'b0 || imem_addr !== frozen) begin n_fail++; $display("FAIL mis_cycle: got v=%b addr=%h expected v=0 addr=%h", valid, imem_addr, frozen); end
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom()) & 32'hFFFF_FFFC, 1'b1);
      n_tests++; if (valid !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL halt_valid[%0d]: got v=%b instr=%h expected v=0 instr=%h", i, valid, instr, NOP); end
      n_tests++; if (fetch_misalign !== 1'b1) begin n_fail++; $display("FAIL halt_sticky[%0d]: got %b expected 1", i, fetch_misalign); end
      n_tests++; if (imem_addr !== frozen) begin n_fail++; $display("FAIL halt_addr[%0d]: got %h expected %h", i, imem_addr, frozen); end
      tick();
    end
    apply(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (fetch_misalign !== 1'b0 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL mis_clear: got mis=%b addr=%h expected mis=0 addr=%h", fetch_misalign, imem_addr, RST_PC); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (pc !== RST_PC || valid !== 1'b1) begin n_fail++; $display("FAIL mis_resume: got pc=%h v=%b expected pc=%h v=1", pc, valid, RST_PC); end
    tick();
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 3; i++) begin apply(1'b0, 1'b0, 32'h0, 1'b1); tick(); end
    apply(1'b0, 1'b0, 32'h0, 1'b0);
    n_tests++; if (valid !== 1'b0 || pc !== RST_PC) begin n_fail++; $display("FAIL midrst_now: got v=%b pc=%h expected v=0 pc=%h", valid, pc, RST_PC); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (valid !== 1'b0 || pc !== RST_PC) begin n_fail++; $display("FAIL midrst_boot: got v=%b pc=%h expected v=0 pc=%h", valid, pc, RST_PC); end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (valid !== 1'b1 || pc !== RST_PC || instr !== (RST_PC ^ SALT)) begin n_fail++; $display("FAIL midrst_resume: got v=%b pc=%h instr=%h expected v=1 pc=%h", valid, pc, instr, RST_PC); end
    tick();
  endtask

  task automatic test_random();
    logic        st, rd, rn;
    logic [31:0] rpc;
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 5) == 0);
      rn  = ($urandom_range(0, 29) != 0);
      rpc = $urandom();
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      apply(st, rd, rpc, rn);
      n_tests++; if (valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, valid, exp_valid); end
      n_tests++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, pc, exp_pc); end
      n_tests++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, imem_addr, exp_addr); end
      n_tests++; if (instr !== exp_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, instr, exp_instr); end
      n_tests++; if (fetch_misalign !== exp_mis) begin n_fail++; $display("FAIL rnd_misalign[%0d]: got %b expected %b", i, fetch_misalign, exp_mis); end
      tick();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
